bram_port_arbiter: RTL and testbench

//  Shares one single-clock port of the dual-port bram between two requesters (0: fetch, 1: load/store).

---
 rtl/arb_pkg.sv | 16 +
 rtl/rr_pick2.sv | 27 ++
 rtl/bram_port_arbiter.sv | 130 +++++++++++++
 tb/tb_bram_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the two-requester bram port arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_t;

    typedef logic port_idx_t;

    // One-hot grant of a 2-input chooser to the winning port index.
    function automatic port_idx_t gnt_to_idx(input logic [1:0] gnt);
        return gnt[1];
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-input chooser: sole requester wins; on conflict round-robin (mode_i=1)
// favours the port not granted last, fixed priority (mode_i=0) favours port 0.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       mode_i,
    output logic [1:0] gnt_o
);

    // Combinational one-hot selection.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01: gnt_o = 2'b01;
            2'b10: gnt_o = 2'b10;
            2'b11: begin
                if (mode_i && !last_i) begin
                    gnt_o = 2'b10;
                end else begin
                    gnt_o = 2'b01;
                end
            end
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one synchronous bram port between a fetch (0) and a load/store (1)
// requester; reads occupy the port for two cycles, writes for one.
module bram_port_arbiter
    import arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_0,
    input  logic                  i_req_1,
    input  logic                  i_wr_0,
    input  logic                  i_wr_1,
    input  logic [ADDR_WIDTH-1:0] i_addr_0,
    input  logic [ADDR_WIDTH-1:0] i_addr_1,
    input  logic [DATA_WIDTH-1:0] i_data_0,
    input  logic [DATA_WIDTH-1:0] i_data_1,
    output logic                  o_gnt_0,
    output logic                  o_gnt_1,
    output logic                  o_rvalid_0,
    output logic                  o_rvalid_1,
    output logic [DATA_WIDTH-1:0] o_rdata_0,
    output logic [DATA_WIDTH-1:0] o_rdata_1,
    output logic                  o_mem_write,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    input  logic [DATA_WIDTH-1:0] i_mem_data
);

    arb_state_t            state_q;
    port_idx_t             rd_port_q;
    port_idx_t             last_gnt_q;
    port_idx_t             pick_s;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [DATA_WIDTH-1:0] rdata_0_q;
    logic [DATA_WIDTH-1:0] rdata_1_q;
    logic                  rvalid_0_q;
    logic                  rvalid_1_q;
    logic [1:0]            pick_gnt_s;
    logic [1:0]            gnt_s;
    logic                  mem_write_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_data_s;

    rr_pick2 u_pick (
        .req_i  ({i_req_1, i_req_0}),
        .last_i (last_gnt_q),
        .mode_i (ROUND_ROBIN),
        .gnt_o  (pick_gnt_s)
    );

    assign pick_s = gnt_to_idx(pick_gnt_s);

    // Request mux onto the bram port; the address is held on the read during RD_WAIT.
    always_comb begin
        gnt_s       = 2'b00;
        mem_write_s = 1'b0;
        mem_addr_s  = i_addr_0;
        mem_data_s  = i_data_0;
        case (state_q)
            IDLE: begin
                gnt_s = pick_gnt_s;
                if (pick_gnt_s[1]) begin
                    mem_write_s = i_wr_1;
                    mem_addr_s  = i_addr_1;
                    mem_data_s  = i_data_1;
                end else if (pick_gnt_s[0]) begin
                    mem_write_s = i_wr_0;
                end else begin
                    mem_write_s = 1'b0;
                end
            end
            RD_WAIT: mem_addr_s = rd_addr_q;
            default: mem_addr_s = i_addr_0;
        endcase
    end

    // Arbiter FSM with read-return registers; rvalid pulses for exactly one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            rd_port_q  <= 1'b0;
            last_gnt_q <= 1'b1;
            rd_addr_q  <= {ADDR_WIDTH{1'b0}};
            rdata_0_q  <= {DATA_WIDTH{1'b0}};
            rdata_1_q  <= {DATA_WIDTH{1'b0}};
            rvalid_0_q <= 1'b0;
            rvalid_1_q <= 1'b0;
        end else begin
            rvalid_0_q <= 1'b0;
            rvalid_1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|gnt_s) begin
                        last_gnt_q <= pick_s;
                        if (!mem_write_s) begin
                            state_q   <= RD_WAIT;
                            rd_port_q <= pick_s;
                            rd_addr_q <= mem_addr_s;
                        end
                    end
                end
                RD_WAIT: begin
                    if (rd_port_q) begin
                        rdata_1_q  <= i_mem_data;
                        rvalid_1_q <= 1'b1;
                    end else begin
                        rdata_0_q  <= i_mem_data;
                        rvalid_0_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_gnt_0     = gnt_s[0];
    assign o_gnt_1     = gnt_s[1];
    assign o_rvalid_0  = rvalid_0_q;
    assign o_rvalid_1  = rvalid_1_q;
    assign o_rdata_0   = rdata_0_q;
    assign o_rdata_1   = rdata_1_q;
    assign o_mem_write = mem_write_s;
    assign o_mem_addr  = mem_addr_s;
    assign o_mem_data  = mem_data_s;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench: a round-robin and a fixed-priority arbiter, each on its own bram,
// driven by the same directed vectors and checked against a schedule model.
module tb_bram_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, wr0, req1, wr1;
    logic [3:0] addr0, addr1;
    logic [7:0] data0, data1;

    logic [1:0] gnt0_s, gnt1_s, rv0_s, rv1_s, mwr_s;
    logic [7:0] rd0_s   [2];
    logic [7:0] rd1_s   [2];
    logic [3:0] maddr_s [2];
    logic [7:0] mdat_s  [2];
    logic [7:0] bq      [2];
    logic [7:0] bmem    [2][16];

    int checks = 0;
    int errors = 0;

    bram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ROUND_ROBIN(1'b1)) u_dut_rr (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_0(req0), .i_req_1(req1), .i_wr_0(wr0), .i_wr_1(wr1),
        .i_addr_0(addr0), .i_addr_1(addr1), .i_data_0(data0), .i_data_1(data1),
        .o_gnt_0(gnt0_s[0]), .o_gnt_1(gnt1_s[0]),
        .o_rvalid_0(rv0_s[0]), .o_rvalid_1(rv1_s[0]),
        .o_rdata_0(rd0_s[0]), .o_rdata_1(rd1_s[0]),
        .o_mem_write(mwr_s[0]), .o_mem_addr(maddr_s[0]), .o_mem_data(mdat_s[0]),
        .i_mem_data(bq[0])
    );

    bram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ROUND_ROBIN(1'b0)) u_dut_fp (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_0(req0), .i_req_1(req1), .i_wr_0(wr0), .i_wr_1(wr1),
        .i_addr_0(addr0), .i_addr_1(addr1), .i_data_0(data0), .i_data_1(data1),
        .o_gnt_0(gnt0_s[1]), .o_gnt_1(gnt1_s[1]),
        .o_rvalid_0(rv0_s[1]), .o_rvalid_1(rv1_s[1]),
        .o_rdata_0(rd0_s[1]), .o_rdata_1(rd1_s[1]),
        .o_mem_write(mwr_s[1]), .o_mem_addr(maddr_s[1]), .o_mem_data(mdat_s[1]),
        .i_mem_data(bq[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous brams, read-before-write on the same edge.
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (mwr_s[m]) bmem[m][maddr_s[m]] <= mdat_s[m];
            bq[m] <= bmem[m][maddr_s[m]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each instance's port is either free or reserved by a read
    // whose reply is scheduled two cycles after its grant.
    int         cyc = 0;
    logic [7:0] mm    [2][16];
    bit         pv    [2];
    int         pdue  [2];
    bit         pport [2];
    logic [7:0] pdat  [2];
    logic [3:0] paddr [2];
    bit         mlast [2];
    logic [7:0] mrd   [2][2];
    bit         e_g0, e_g1, e_w, e_rv0, e_rv1, busy;
    logic [3:0] e_a;
    logic [7:0] e_d;

    always @(negedge clk) begin
        cyc++;
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                pv[m] = 1'b0;
                mlast[m] = 1'b1;
                mrd[m][0] = 8'h00;
                mrd[m][1] = 8'h00;
                chk("rst_rvalid", {rv1_s[m], rv0_s[m]}, 32'd0);
                chk("rst_rdata0", rd0_s[m], 32'd0);
                chk("rst_rdata1", rd1_s[m], 32'd0);
            end else begin
                e_rv0 = pv[m] && (pdue[m] == cyc) && !pport[m];
                e_rv1 = pv[m] && (pdue[m] == cyc) && pport[m];
                if (pv[m] && (pdue[m] == cyc)) begin
                    mrd[m][pport[m]] = pdat[m];
                    pv[m] = 1'b0;
                end
                busy = pv[m] && (pdue[m] == cyc + 1);
                e_g0 = 1'b0; e_g1 = 1'b0; e_w = 1'b0; e_a = addr0; e_d = data0;
                if (busy) e_a = paddr[m];
                else if (req0 && req1) begin
                    if (m == 0 && !mlast[m]) e_g1 = 1'b1;
                    else e_g0 = 1'b1;
                end
                else if (req0) e_g0 = 1'b1;
                else if (req1) e_g1 = 1'b1;
                if (e_g1) begin
                    e_a = addr1;
                    e_d = data1;
                end
                if (e_g0 || e_g1) begin
                    e_w = e_g1 ? wr1 : wr0;
                    mlast[m] = e_g1;
                    if (e_w) mm[m][e_a] = e_d;
                    else begin
                        pv[m] = 1'b1; pdue[m] = cyc + 2; pport[m] = e_g1;
                        pdat[m] = mm[m][e_a]; paddr[m] = e_a;
                    end
                end
                chk("m_gnt0", gnt0_s[m], e_g0);
                chk("m_gnt1", gnt1_s[m], e_g1);
                chk("m_write", mwr_s[m], e_w);
                chk("m_addr", maddr_s[m], e_a);
                if (e_w) chk("m_wdata", mdat_s[m], e_d);
                chk("m_rvalid0", rv0_s[m], e_rv0);
                chk("m_rvalid1", rv1_s[m], e_rv1);
                chk("m_rdata0", rd0_s[m], mrd[m][0]);
                chk("m_rdata1", rd1_s[m], mrd[m][1]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r0, input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                          input logic r1, input logic w1, input logic [3:0] a1, input logic [7:0] d1);
        req0 = r0; wr0 = w0; addr0 = a0; data0 = d0;
        req1 = r1; wr1 = w1; addr1 = a1; data1 = d1;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    logic [3:0] s0a, s1a, s0b, s1b;

    initial begin
        #50000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle();
        tick(); tick();
        rst_n = 1'b1;

        // 1: write then read back on port 0
        set_in(1'b1, 1'b1, 4'h3, 8'hAA, 1'b0, 1'b0, 4'h0, 8'h00);
        #2 chk("s1_wr_gnt0", {gnt0_s[1], gnt0_s[0]}, 32'h3);
        tick();
        set_in(1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        #2 chk("s1_rd_gnt0", {gnt0_s[1], gnt0_s[0]}, 32'h3);
        tick();
        idle();
        #2 chk("s1_wait_rvalid", {rv0_s[1], rv0_s[0]}, 32'h0);
        tick();
        #2 chk("s1_rvalid0", {rv0_s[1], rv0_s[0]}, 32'h3);
        chk("s1_rdata0_rr", rd0_s[0], 32'hAA);
        chk("s1_rdata0_fp", rd0_s[1], 32'hAA);
        tick();

        // preload addresses 1, 2, 5 through port 0, then reset
        set_in(1'b1, 1'b1, 4'h1, 8'h11, 1'b0, 1'b0, 4'h0, 8'h00); tick();
        set_in(1'b1, 1'b1, 4'h2, 8'h22, 1'b0, 1'b0, 4'h0, 8'h00); tick();
        set_in(1'b1, 1'b1, 4'h5, 8'h5A, 1'b0, 1'b0, 4'h0, 8'h00); tick();
        idle();
        rst_n = 1'b0;
        #2 chk("rst_rdata0_cleared", rd0_s[0], 32'h00);
        tick();
        rst_n = 1'b1;

        // 2: simultaneous reads after reset
        set_in(1'b1, 1'b0, 4'h1, 8'h00, 1'b1, 1'b0, 4'h2, 8'h00);
        #2 chk("s2_first_gnt0", {gnt0_s[1], gnt0_s[0]}, 32'h3);
        chk("s2_first_gnt1", {gnt1_s[1], gnt1_s[0]}, 32'h0);
        tick();
        set_in(1'b0, 1'b0, 4'h1, 8'h00, 1'b1, 1'b0, 4'h2, 8'h00);
        #2 chk("s2_busy_gnt1", {gnt1_s[1], gnt1_s[0]}, 32'h0);
        tick();
        #2 chk("s2_rvalid0", {rv0_s[1], rv0_s[0]}, 32'h3);
        chk("s2_rdata0", rd0_s[0], 32'h11);
        chk("s2_gnt1", {gnt1_s[1], gnt1_s[0]}, 32'h3);
        tick();
        idle();
        tick();
        #2 chk("s2_rvalid1", {rv1_s[1], rv1_s[0]}, 32'h3);
        chk("s2_rdata1", rd1_s[0], 32'h22);
        tick();

        // 5: port 1 read, port 0 overwrites the same address in the rvalid cycle
        set_in(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h5, 8'h00);
        #2 chk("s5_gnt1", {gnt1_s[1], gnt1_s[0]}, 32'h3);
        tick();
        idle(); tick();
        set_in(1'b1, 1'b1, 4'h5, 8'h55, 1'b0, 1'b0, 4'h0, 8'h00);
        #2 chk("s5_rvalid1", {rv1_s[1], rv1_s[0]}, 32'h3);
        chk("s5_old_rdata1", rd1_s[0], 32'h5A);
        chk("s5_wr_gnt0", {gnt0_s[1], gnt0_s[0]}, 32'h3);
        tick();
        set_in(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h5, 8'h00); tick();
        idle(); tick();
        #2 chk("s5_new_rdata1", rd1_s[0], 32'h55);
        chk("s5_new_rdata1_fp", rd1_s[1], 32'h55);
        tick();

        // 4: reset during RD_WAIT drops the read
        set_in(1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00); tick();
        idle();
        rst_n = 1'b0;
        #2 chk("s4_rvalid_in_rst", {rv0_s[1], rv0_s[0]}, 32'h0);
        tick();
        rst_n = 1'b1;
        #2 chk("s4_no_rvalid", {rv0_s[1], rv0_s[0]}, 32'h0);
        chk("s4_rdata0", rd0_s[0], 32'h00);
        chk("s4_rdata1", rd1_s[0], 32'h00);
        tick();
        set_in(1'b1, 1'b1, 4'h8, 8'h80, 1'b1, 1'b1, 4'h9, 8'h90);
        #2 chk("s4_next_gnt0", {gnt0_s[1], gnt0_s[0]}, 32'h3);
        tick();
        idle(); tick();

        // 3: both hold writes for four cycles, from a fresh reset
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        set_in(1'b1, 1'b1, 4'hA, 8'hC0, 1'b1, 1'b1, 4'hB, 8'hC1);
        for (int i = 0; i < 4; i++) begin
            #2;
            s0a[i] = gnt0_s[0]; s1a[i] = gnt1_s[0];
            s0b[i] = gnt0_s[1]; s1b[i] = gnt1_s[1];
            tick();
        end
        idle();
        chk("s3_rr_gnt0_seq", s0a, 32'h5);
        chk("s3_rr_gnt1_seq", s1a, 32'hA);
        chk("s3_fp_gnt0_seq", s0b, 32'hF);
        chk("s3_fp_gnt1_seq", s1b, 32'h0);
        tick();

        // 6: read addr 10 on port 1, then ten idle cycles
        set_in(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'hA, 8'h00); tick();
        idle(); tick(); tick();
        for (int i = 0; i < 10; i++) begin
            #2;
            chk("s6_write", mwr_s, 32'h0);
            chk("s6_gnt", {gnt1_s, gnt0_s}, 32'h0);
            chk("s6_rvalid", {rv1_s, rv0_s}, 32'h0);
            chk("s6_rdata1", {rd1_s[1], rd1_s[0]}, 32'hC0C0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
